// File: rtl/fifo_pkg.sv
// Shared constants and types for the RAM-backed FIFO.
package fifo_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   cnt_t;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving both ports of an external dual-port RAM.
// Write and read requests go straight to the RAM ports. Popped data comes
// back on ram_dob one cycle later, together with pop_valid.
module ram_fifo_ctrl #(
    parameter int unsigned DATA_W = fifo_pkg::DATA_W,
    parameter int unsigned ADDR_W = fifo_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dia,
    output logic              ram_enb,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_dob
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    // Occupancy flags come from the count register only, so push and pop
    // have no combinational path to full/empty.
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == CNT_W'(0));

    // Accept decisions use pre-edge flags. At full a simultaneous push is
    // refused so the slot being read is never overwritten, and at empty a
    // simultaneous pop is refused because there is no fall-through.
    assign push_ok = push & ~full  & ~rst;
    assign pop_ok  = pop  & ~empty & ~rst;

    // RAM port A (write) and port B (read-address load).
    assign ram_ena   = push_ok;
    assign ram_wea   = push_ok;
    assign ram_addra = wr_ptr;
    assign ram_dia   = push_data;
    assign ram_enb   = pop_ok;
    assign ram_addrb = rd_ptr;

    // Read data returns from the RAM's registered-address output.
    assign pop_data = ram_dob;

    // Pointers, occupancy, return strobe and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            pop_valid <= pop_ok;
            if (push && full) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: a RAM model plus a queue-based reference model
// that is compared against the DUT on every cycle.
module tb_ram_fifo_ctrl;
    import fifo_pkg::*;

    logic              clk;
    logic              rst;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;
    logic              ram_ena;
    logic              ram_wea;
    logic [ADDR_W-1:0] ram_addra;
    logic [DATA_W-1:0] ram_dia;
    logic              ram_enb;
    logic [ADDR_W-1:0] ram_addrb;
    logic [DATA_W-1:0] ram_dob;

    ram_fifo_ctrl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dia   (ram_dia),
        .ram_enb   (ram_enb),
        .ram_addrb (ram_addrb),
        .ram_dob   (ram_dob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 32x4 dual-port RAM with a registered read address.
    logic [DATA_W-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_ena && ram_wea) ram_mem[ram_addra] <= ram_dia;
        if (ram_enb) ram_dob <= ram_mem[ram_addrb];
    end

    // Reference model state.
    data_t mq[$];
    int    m_wr;
    int    m_rd;
    bit    m_ovf;
    bit    m_unf;
    bit    m_pv;
    data_t m_data;
    int    checks;
    int    fails;
    bit    chk_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check RAM controls, advance the model.
    task automatic step(input bit p, input data_t d, input bit q, input bit r);
        bit pok;
        bit qok;
        int n;
        push      = p;
        push_data = d;
        pop       = q;
        rst       = r;
        #1;
        n   = mq.size();
        pok = p && !r && (n != DEPTH);
        qok = q && !r && (n != 0);
        chk("ram_ena",   32'(ram_ena),   32'(pok));
        chk("ram_wea",   32'(ram_wea),   32'(pok));
        chk("ram_enb",   32'(ram_enb),   32'(qok));
        chk("ram_addra", 32'(ram_addra), 32'(m_wr % DEPTH));
        chk("ram_addrb", 32'(ram_addrb), 32'(m_rd % DEPTH));
        chk("ram_dia",   32'(ram_dia),   32'(d));
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_wr  = 0;
            m_rd  = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_pv  = 1'b0;
        end else begin
            if (p && n == DEPTH) m_ovf = 1'b1;
            if (q && n == 0) m_unf = 1'b1;
            m_pv = qok;
            if (qok) begin
                m_data = mq.pop_front();
                m_rd++;
            end
            if (pok) begin
                mq.push_back(d);
                m_wr++;
            end
        end
        @(negedge clk);
    endtask

    // Registered outputs against the model, every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count",     32'(count),     32'(mq.size()));
            chk("full",      32'(full),      32'(mq.size() == DEPTH));
            chk("empty",     32'(empty),     32'(mq.size() == 0));
            chk("overflow",  32'(overflow),  32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_unf));
            chk("pop_valid", 32'(pop_valid), 32'(m_pv));
            if (m_pv) chk("pop_data", 32'(pop_data), 32'(m_data));
        end
    end

    initial begin
        bit rp;
        bit rq;
        bit rr;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = '0;
        rst       = 1'b1;
        checks    = 0;
        fails     = 0;
        chk_en    = 1'b0;
        m_wr      = 0;
        m_rd      = 0;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
        m_pv      = 1'b0;
        m_data    = '0;
        @(negedge clk);
        chk_en = 1'b1;

        // Reset, then idle with no RAM activity.
        repeat (2) step(1'b0, '0, 1'b0, 1'b1);
        chk("lit_rst_count", 32'(count),     32'd0);
        chk("lit_rst_empty", 32'(empty),     32'd1);
        chk("lit_rst_full",  32'(full),      32'd0);
        chk("lit_rst_pv",    32'(pop_valid), 32'd0);
        repeat (10) step(1'b0, '0, 1'b0, 1'b0);

        // Three pushes then three pops.
        for (int k = 1; k <= 3; k++) step(1'b1, DATA_W'(k), 1'b0, 1'b0);
        chk("lit_count3", 32'(count), 32'd3);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("lit_pv_pop",   32'(pop_valid), 32'd1);
            chk("lit_pop_data", 32'(pop_data),  32'(k));
        end
        chk("lit_count0", 32'(count), 32'd0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("lit_pv_idle", 32'(pop_valid), 32'd0);

        // Fill to 32, overflow attempt, drain in order.
        for (int i = 0; i < 32; i++) step(1'b1, DATA_W'(i & 15), 1'b0, 1'b0);
        chk("lit_full",     32'(full),  32'd1);
        chk("lit_count32",  32'(count), 32'd32);
        step(1'b1, DATA_W'(10), 1'b0, 1'b0);
        chk("lit_overflow", 32'(overflow), 32'd1);
        chk("lit_count32b", 32'(count),    32'd32);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("lit_drain", 32'(pop_data), 32'(i & 15));
        end
        step(1'b0, '0, 1'b0, 1'b0);

        // Pop on empty.
        step(1'b0, '0, 1'b1, 1'b0);
        chk("lit_underflow", 32'(underflow), 32'd1);
        chk("lit_unf_pv",    32'(pop_valid), 32'd0);
        chk("lit_unf_count", 32'(count),     32'd0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("lit_flags_clr", 32'({overflow, underflow}), 32'd0);

        // Simultaneous push and pop at count 5, 0 and 32.
        for (int i = 0; i < 5; i++) step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        step(1'b1, DATA_W'($urandom), 1'b1, 1'b0);
        chk("lit_pp5", 32'(count), 32'd5);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, DATA_W'(7), 1'b1, 1'b0);
        chk("lit_pp0_count", 32'(count),     32'd1);
        chk("lit_pp0_pv",    32'(pop_valid), 32'd0);
        for (int i = 0; i < 31; i++) step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        step(1'b1, DATA_W'(5), 1'b1, 1'b0);
        chk("lit_pp32_count", 32'(count), 32'd31);
        chk("lit_pp32_pv",    32'(pop_valid), 32'd1);
        for (int i = 0; i < 31; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Streaming 100 words: pointers wrap several times.
        step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        repeat (100) step(1'b1, DATA_W'($urandom), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("lit_stream_empty", 32'(empty), 32'd1);

        // Random traffic: push-heavy, pop-heavy, then balanced with rare resets.
        repeat (150) begin
            rp = ($urandom_range(0, 99) < 80);
            rq = ($urandom_range(0, 99) < 30);
            step(rp, DATA_W'($urandom), rq, 1'b0);
        end
        repeat (150) begin
            rp = ($urandom_range(0, 99) < 30);
            rq = ($urandom_range(0, 99) < 80);
            step(rp, DATA_W'($urandom), rq, 1'b0);
        end
        repeat (300) begin
            rp = ($urandom_range(0, 99) < 55);
            rq = ($urandom_range(0, 99) < 50);
            rr = ($urandom_range(0, 99) == 0);
            step(rp, DATA_W'($urandom), rq, rr);
        end

        // Reset mid-stream at count 7 with a pop in flight and flags set.
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("lit_pre_rst_count", 32'(count), 32'd7);
        step(1'b1, DATA_W'(3), 1'b1, 1'b1);
        chk("lit_rst_mid_count", 32'(count),     32'd0);
        chk("lit_rst_mid_empty", 32'(empty),     32'd1);
        chk("lit_rst_mid_pv",    32'(pop_valid), 32'd0);
        chk("lit_rst_mid_flags", 32'({overflow, underflow}), 32'd0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
